// File: rtl/shift_pkg.sv
// Shared shift/rotate mode encodings for the barrel shifter and the ALU decoder.
// Encodings 101..111 all select pass-through.
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_SLL = 3'b000,
        MODE_SRL = 3'b001,
        MODE_SRA = 3'b010,
        MODE_ROL = 3'b011,
        MODE_ROR = 3'b100
    } shift_mode_e;

    localparam int unsigned MODE_W = 3;

    // Canonical pass-through code a decoder should emit for non-shift operations.
    localparam logic [MODE_W-1:0] MODE_PASS = 3'b101;

    function automatic logic mode_is_shift(input logic [MODE_W-1:0] m);
        return (m <= MODE_ROR);
    endfunction

    function automatic logic mode_is_rotate(input logic [MODE_W-1:0] m);
        return (m == MODE_ROL) || (m == MODE_ROR);
    endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One combinational barrel-shifter stage: shifts or rotates by 2^K when enabled
// and selects the bit that leaves the word as the new carry.
module barrel_shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K     = 0
) (
    input  logic [WIDTH-1:0]  data_i,
    input  logic              en_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic              carry_i,
    output logic [WIDTH-1:0]  data_o,
    output logic              carry_o
);

    localparam int SH = 1 << K;

    always_comb begin
        data_o  = data_i;
        carry_o = carry_i;
        if (en_i) begin
            case (mode_i)
                MODE_SLL: begin
                    data_o  = data_i << SH;
                    carry_o = data_i[WIDTH-SH];
                end
                MODE_SRL: begin
                    data_o  = data_i >> SH;
                    carry_o = data_i[SH-1];
                end
                MODE_SRA: begin
                    data_o  = $signed(data_i) >>> SH;
                    carry_o = data_i[SH-1];
                end
                MODE_ROL: begin
                    data_o  = (data_i << SH) | (data_i >> (WIDTH - SH));
                    carry_o = 1'b0;
                end
                MODE_ROR: begin
                    data_o  = (data_i >> SH) | (data_i << (WIDTH - SH));
                    carry_o = 1'b0;
                end
                default: begin
                    data_o  = data_i;
                    carry_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: SHW shift stages, each followed by a register bank,
// with a global valid/ready stall, synchronous flush and asynchronous reset.
module barrel_shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [SHW-1:0]    b,
    input  logic [MODE_W-1:0] mode,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  c,
    output logic              carry,
    output logic              zero
);

    typedef struct packed {
        logic              valid;
        logic [WIDTH-1:0]  data;
        logic [SHW-1:0]    b;
        logic [MODE_W-1:0] mode;
        logic              carry;
    } stage_t;

    stage_t           stage_q  [SHW];
    stage_t           stage_d  [SHW];
    stage_t           src      [SHW];
    logic [WIDTH-1:0] sh_data  [SHW];
    logic             sh_carry [SHW];

    logic stall;
    logic advance;

    assign stall    = stage_q[SHW-1].valid && !out_ready;
    assign advance  = !stall;
    assign in_ready = !stall && !flush;

    // Stage 0 reads the input port; stage k reads register bank k-1.
    always_comb begin
        src[0]       = '0;
        src[0].valid = in_valid && in_ready;
        src[0].data  = a;
        src[0].b     = b;
        src[0].mode  = mode;
        src[0].carry = 1'b0;
        for (int unsigned k = 1; k < SHW; k++) begin
            src[k] = stage_q[k-1];
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .data_i  (src[k].data),
            .en_i    (src[k].b[k]),
            .mode_i  (src[k].mode),
            .carry_i (src[k].carry),
            .data_o  (sh_data[k]),
            .carry_o (sh_carry[k])
        );
    end

    always_comb begin
        for (int unsigned k = 0; k < SHW; k++) begin
            stage_d[k]       = src[k];
            stage_d[k].data  = sh_data[k];
            stage_d[k].carry = sh_carry[k];
        end
    end

    // Flush is applied after the advance so it wins over both stall and a same-cycle accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < SHW; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < SHW; k++) begin
                if (advance) begin
                    stage_q[k] <= stage_d[k];
                end
                if (flush) begin
                    stage_q[k].valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = stage_q[SHW-1].valid;
    assign c         = stage_q[SHW-1].data;
    assign carry     = stage_q[SHW-1].carry;
    assign zero      = (c == '0);

    // The final bank's shift amount and mode have no consumer past the last stage.
    logic unused_tail;
    assign unused_tail = ^{stage_q[SHW-1].b, stage_q[SHW-1].mode};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Randomized and directed scoreboard bench for barrel_shift_pipe at WIDTH=32.
module tb_barrel_shift_pipe;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   b;
    logic [2:0]       mode;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             carry;
    logic             zero;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH:0] exp_q[$];
    int pushes;
    int pops;
    int cyc;
    int first_pop;
    int last_pop;

    barrel_shift_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .carry     (carry),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Whole-word reference: {carry, result} for mode m and total shift n.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] av, input int n, input logic [2:0] m);
        logic [2*WIDTH-1:0] dbl;
        logic [WIDTH-1:0]   r;
        logic               cy;
        dbl = {av, av};
        cy  = 1'b0;
        case (m)
            3'd0: begin r = av << n; if (n != 0) cy = av[WIDTH-n]; end
            3'd1: begin r = av >> n; if (n != 0) cy = av[n-1]; end
            3'd2: begin r = $signed(av) >>> n; if (n != 0) cy = av[n-1]; end
            3'd3: begin dbl = dbl << n; r = dbl[2*WIDTH-1:WIDTH]; end
            3'd4: begin dbl = dbl >> n; r = dbl[WIDTH-1:0]; end
            default: r = av;
        endcase
        return {cy, r};
    endfunction

    // Inputs are set at edge+1; evaluate transfers at edge+2, then advance one clock.
    task automatic cycle();
        logic [WIDTH:0] e;
        #1;
        if (flush) check("flush_in_ready", in_ready, 0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("c", c, e[WIDTH-1:0]);
                check("carry", carry, e[WIDTH]);
                check("zero", zero, e[WIDTH-1:0] == 0);
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, mode));
            pushes++;
        end
        @(posedge clk);
        #1;
        if (flush) exp_q.delete();
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_done", exp_q.size(), 0);
    endtask

    task automatic single_op(input string tag, input logic [WIDTH-1:0] av, input logic [SHW-1:0] bv,
                             input logic [2:0] mv, input logic [WIDTH-1:0] ec, input logic ecy);
        int n;
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        mode      = mv;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            cycle();
            n++;
        end
        check({tag, "_latency"}, n, SHW);
        check({tag, "_c"}, c, ec);
        check({tag, "_carry"}, carry, ecy);
        check({tag, "_zero"}, zero, ec == 0);
        cycle();
    endtask

    initial begin
        logic [WIDTH:0] e;
        int p0;
        int q0;
        int n;

        pushes = 0; pops = 0; cyc = 0; first_pop = -1; last_pop = -1;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 5'd3; mode = 3'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_c", c, 0);
        check("rst_carry", carry, 0);
        check("rst_zero", zero, 1);
        in_valid = 1'b0;
        #3 rst = 1'b0;
        #1 check("rst_release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        single_op("sra_b4", 32'h8000_0001, 5'd4, 3'd2, 32'hF800_0000, 1'b0);
        single_op("sll_b1", 32'h8000_0001, 5'd1, 3'd0, 32'h0000_0002, 1'b1);
        single_op("ror_b1", 32'h8000_0001, 5'd1, 3'd4, 32'hC000_0000, 1'b0);
        single_op("srl_to_zero", 32'h0000_0008, 5'd4, 3'd1, 32'h0000_0000, 1'b1);
        single_op("pass_110", 32'h1234_5678, 5'd7, 3'd6, 32'h1234_5678, 1'b0);

        // Back-to-back random stream: every mode gets b=0 and b=31 plus random amounts.
        p0 = pops; first_pop = -1; last_pop = -1;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            a        = $urandom;
            mode     = 3'(i % 8);
            case (i / 8)
                0:       b = 5'd0;
                1:       b = 5'd31;
                default: b = 5'($urandom);
            endcase
            cycle();
        end
        drain(40);
        check("b2b_count", pops - p0, 32);
        check("b2b_spacing", last_pop - first_pop, 31);

        // Fill the pipe against a blocked consumer, hold, then release.
        p0 = pops; q0 = pushes; n = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        while (in_ready && n < 50) begin
            a = $urandom; b = 5'($urandom); mode = 3'($urandom_range(0, 7));
            cycle();
            n++;
        end
        check("stall_fill", pushes - q0, SHW);
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            cycle();
            e = exp_q[0];
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_c", c, e[WIDTH-1:0]);
            check("stall_carry", carry, e[WIDTH]);
        end
        check("stall_depth", exp_q.size(), SHW);
        drain(40);
        check("stall_count", pops - p0, SHW);

        // Flush with three operands in flight and a concurrent input.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = $urandom; b = 5'($urandom); mode = 3'($urandom_range(0, 4));
            cycle();
        end
        flush = 1'b1; in_valid = 1'b1; a = $urandom;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < SHW; i++) begin
            check("flush_out_valid", out_valid, 0);
            cycle();
        end
        e = model(32'hA5A5_0F0F, 13, 3'd3);
        single_op("post_flush", 32'hA5A5_0F0F, 5'd13, 3'd3, e[WIDTH-1:0], e[WIDTH]);

        // Asynchronous reset pulse mid-stream.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = $urandom | 32'h1; b = 5'($urandom); mode = 3'($urandom_range(0, 7));
            cycle();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_zero", zero, 1);
        check("async_rst_c", c, 0);
        check("async_rst_carry", carry, 0);
        #3 rst = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < SHW + 3; i++) begin
            check("rst_no_stale", out_valid, 0);
            cycle();
        end
        e = model(32'h0F00_00F0, 31, 3'd0);
        single_op("post_rst", 32'h0F00_00F0, 5'd31, 3'd0, e[WIDTH-1:0], e[WIDTH]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/barrel_shift_pipe.md
BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; power of two, 8..64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand valid.
REQ-006 SHALL have port in_ready  output  1  pipeline accepts operand.
REQ-007 SHALL have port a  input  WIDTH  operand.
REQ-008 SHALL have port b  input  SHW  shift amount.
REQ-009 SHALL have port mode  input  3  operation select.
REQ-010 SHALL have port flush  input  1  synchronous pipeline clear.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port c  output  WIDTH  result.
REQ-014 SHALL have port carry  output  1  last bit shifted out.
REQ-015 SHALL have port zero  output  1  c equals zero.

Function
REQ-016 Modes SHALL be: 000 SLL, 001 SRL, 010 SRA (sign fill from a[WIDTH-1]), 011 ROL, 100 ROR; 101-111 pass a unchanged, carry 0.
REQ-017 Shift SHALL be decomposed into SHW stages; stage k shifts by 2^k when b[k]=1; one register bank after each stage; latency exactly SHW cycles from accepted input to out_valid.
REQ-018 Each stage register SHALL carry data, remaining b bits, mode, carry and a valid bit.
REQ-019 carry SHALL be updated at stage k when b[k]=1: right shifts take stage-input bit 2^k-1, SLL takes bit WIDTH-2^k; rotates and pass-through force carry 0; b=0 gives carry 0.
REQ-020 zero SHALL be combinational on c.
REQ-021 Transfer SHALL occur on in_valid && in_ready (input) and out_valid && out_ready (output).
REQ-022 Pipeline SHALL stall globally when out_valid && !out_ready; stall = hold all stage registers; in_ready = !stall.
REQ-023 Bubbles SHALL advance when not stalled (no bubble collapse); throughput one result per cycle while out_ready=1.
REQ-024 c, carry, mode-held data SHALL remain stable while out_valid && !out_ready.
REQ-025 flush SHALL clear all valid bits next edge, overriding stall and same-cycle input acceptance; data registers need not clear; in_ready SHALL be 0 during the flush cycle.
REQ-026 Shift amount SHALL be modulo WIDTH by construction (b is SHW bits); no out-of-range case exists.

Reset
REQ-027 While rst=1 all valid bits SHALL be 0, c=0, carry=0, so out_valid=0, zero=1.
REQ-028 rst asserted mid-operation SHALL discard all in-flight operands; no result emerges after release.
REQ-029 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-030 Mode encodings and the pass-through default SHALL live in shared package shift_pkg, reused by the ALU decoder.
REQ-031 One sub-module barrel_shift_stage (parameters WIDTH, K; combinational shift-by-2^k plus carry select) SHALL be instantiated SHW times via generate; registers stay in barrel_shift_pipe.

Verification (WIDTH=32)
REQ-032 a=0x8000_0001, b=4, SRA, out_ready=1 -> after 5 cycles c=0xF800_0000, carry=0, zero=0.
REQ-033 a=0x8000_0001, b=1, SLL -> c=0x0000_0002, carry=1; same with ROR b=1 -> c=0xC000_0000, carry=0.
REQ-034 Back-to-back 32 random ops, out_ready=1 -> 32 results in order, one per cycle, matching model for all five modes and b in {0,31}.
REQ-035 out_ready=0 for 10 cycles with pipe full -> in_ready=0, c stable, no result lost or duplicated after release.
REQ-036 flush with 3 ops in flight plus concurrent in_valid -> out_valid stays 0 for SHW cycles; next op accepted normally.
REQ-037 rst pulse mid-stream, asynchronous to clk -> out_valid=0 immediately, zero=1, no stale result after release.
